// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text path: screen geometry, the fill
// character and the writer FSM state type. The display stage imports the
// same geometry constants so both sides agree on the buffer layout.
package vga_text_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 30;
  localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEX   = 2'd1,
    CLEAR = 2'd2
  } writer_state_t;

endpackage

// File: rtl/vga_text_writer_hex_to_ascii.sv
// Nibble to uppercase ASCII hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digits and letters sit in two separate ASCII runs, so pick the base.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'b0000, nibble};
    end else begin
      ascii = 8'h37 + {4'b0000, nibble};
    end
  end

endmodule

// File: rtl/vga_text_writer.sv
// Command-driven writer for the VGA text buffer. Takes one command at a
// time over valid/ready and renders a 32-bit value as uppercase hex at a
// row/column, one character per clock on the wen/w_addr/w_data port.
// Define VGA_TEXT_WRITER_CLEAR_EN to build the clear-screen command, which
// fills every visible cell with a space.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_clear,
  input  logic [4:0]        req_row,
  input  logic [6:0]        req_col,
  input  logic [3:0]        req_digits,
  input  logic [31:0]       req_value,
  output logic              busy,
  output logic              wen,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_data
);

  // Address arithmetic runs one bit wider than the buffer address so the
  // wrap compare never loses the carry.
  localparam logic [ADDR_W:0] CELLS_W = (ADDR_W+1)'(COLS * ROWS);
  localparam logic [ADDR_W:0] LAST_W  = CELLS_W - (ADDR_W+1)'(1);

  writer_state_t state, state_next;

  logic [31:0]       shift_q, shift_next;
  logic [2:0]        remain_q, remain_next;
  logic              wen_next, ready_next;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        data_next;

  logic [3:0]        req_n;
  logic [31:0]       req_aligned;
  logic [ADDR_W:0]   start_raw, start_wrap;
  logic [ADDR_W:0]   addr_inc, addr_wrapped;
  logic [3:0]        nibble_sel;
  logic [7:0]        nibble_char;

`ifndef VGA_TEXT_WRITER_CLEAR_EN
  logic unused_clear;
  assign unused_clear = req_clear;
`endif

  // Decode the incoming command: digit count, value left-aligned so the
  // first printed nibble is always [31:28], and the wrapped start address.
  // Row <= 31 and col <= 127 keep the raw sum below twice the screen size,
  // so a single conditional subtract implements the modulo.
  always_comb begin
    req_n       = (req_digits == 4'd0 || req_digits > 4'd8) ? 4'd8 : req_digits;
    req_aligned = req_value << {4'd8 - req_n, 2'b00};
    start_raw   = (ADDR_W+1)'(req_row) * (ADDR_W+1)'(COLS) + (ADDR_W+1)'(req_col);
    start_wrap  = (start_raw >= CELLS_W) ? start_raw - CELLS_W : start_raw;
  end

  // Next write address: step by one and fold back to cell 0 past the end.
  always_comb begin
    addr_inc     = {1'b0, w_addr} + (ADDR_W+1)'(1);
    addr_wrapped = (addr_inc >= CELLS_W) ? '0 : addr_inc;
  end

  // The first character comes straight from the request; later ones from
  // the shift register holding the not-yet-printed nibbles.
  always_comb begin
    nibble_sel = (state == IDLE) ? req_aligned[31:28] : shift_q[31:28];
  end

  hex_to_ascii u_hex_to_ascii (
    .nibble (nibble_sel),
    .ascii  (nibble_char)
  );

  // Next-state and next-output logic; outputs are registered below so the
  // first character appears the cycle after the handshake.
  always_comb begin
    state_next  = state;
    wen_next    = 1'b0;
    ready_next  = 1'b0;
    addr_next   = w_addr;
    data_next   = w_data;
    shift_next  = shift_q;
    remain_next = remain_q;
    case (state)
      IDLE: begin
        ready_next = 1'b1;
        if (req_valid) begin
          ready_next  = 1'b0;
          wen_next    = 1'b1;
          state_next  = HEX;
          addr_next   = start_wrap[ADDR_W-1:0];
          data_next   = nibble_char;
          shift_next  = req_aligned << 4;
          remain_next = 3'(req_n - 4'd1);
`ifdef VGA_TEXT_WRITER_CLEAR_EN
          if (req_clear) begin
            state_next = CLEAR;
            addr_next  = '0;
            data_next  = CHAR_SPACE;
          end
`endif
        end
      end
      HEX: begin
        if (remain_q == 3'd0) begin
          state_next = IDLE;
          ready_next = 1'b1;
        end else begin
          wen_next    = 1'b1;
          addr_next   = addr_wrapped[ADDR_W-1:0];
          data_next   = nibble_char;
          shift_next  = shift_q << 4;
          remain_next = remain_q - 3'd1;
        end
      end
`ifdef VGA_TEXT_WRITER_CLEAR_EN
      CLEAR: begin
        if ({1'b0, w_addr} == LAST_W) begin
          state_next = IDLE;
          ready_next = 1'b1;
        end else begin
          wen_next  = 1'b1;
          addr_next = addr_inc[ADDR_W-1:0];
          data_next = CHAR_SPACE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen       <= 1'b0;
      w_addr    <= '0;
      w_data    <= 8'h00;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      shift_q   <= 32'h0;
      remain_q  <= 3'd0;
    end else begin
      wen       <= wen_next;
      w_addr    <= addr_next;
      w_data    <= data_next;
      req_ready <= ready_next;
      busy      <= ~ready_next;
      shift_q   <= shift_next;
      remain_q  <= remain_next;
    end
  end

endmodule
